mem_portb_arbiter: RTL and testbench
====================================

Name: mem_portb_arbiter

Overview:
- Sequences and shares the EXRAM port B between two requesters:
  - requester 0: display/seg refresh fetch engine;
  - requester 1: DMA/IO engine.
- Port B is currently tied off while the CPU owns port A. This block makes port B usable.
- Performs round-robin arbitration, single-outstanding-transaction sequencing around the RAM's one-cycle synchronous read latency, and decode of the memory-mapped IO window (switches, LED/seg register).

Parameters:
- WIDTH, 16, data width of RAM words and requester data buses.
- ADDR_WIDTH, 16, address width.
- IO_MEM, 16'hCFFD, base of IO window; addresses >= IO_MEM are IO-decoded.
- SWITCHES_LOC, 16'hCFFD, read-only switches location.
- LEDS_LOC, 16'hCFFE, read/write seg display value register.

Ports:
- clk  in  1  system clock (50 MHz); all state changes on posedge.
- reset  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  request from requester 0 / 1; held high until gnt.
- we0 / we1  in  1  1 = write, 0 = read; sampled with req.
- addr0 / addr1  in  ADDR_WIDTH  request address.
- wdata0 / wdata1  in  WIDTH  write data.
- gnt0 / gnt1  out  1  one-cycle pulse: request accepted.
- rvalid0 / rvalid1  out  1  one-cycle pulse: rdata valid for that requester.
- rdata  out  WIDTH  read data (shared; qualified by rvalid0/1).
- switches  in  8  board switches.
- seg_value  out  WIDTH  registered value for hexTo7Seg decoders.
- address_b  out  ADDR_WIDTH  RAM port B address.
- data_b  out  WIDTH  RAM port B write data.
- wren_b  out  1  RAM port B write enable.
- q_b  in  WIDTH  RAM port B read data; valid the cycle after address_b is sampled.

Behaviour:
- Reset (async, reset==0): FSM=IDLE, all gnt/rvalid/wren_b=0, address_b=0, data_b=0, rdata=0, seg_value=0, last_grant=1 (so requester 0 wins first tie). Any in-flight transaction is dropped; no write completes after reset asserts.
- FSM states IDLE, ACCESS, READ_WAIT.
- IDLE, any req high:
  - Choose winner: if only one requester asserts, it wins. If both assert, winner = requester != last_grant.
  - Latch winner's we/addr/wdata plus its id into internal registers, update last_grant, go to ACCESS.
  - No req: stay in IDLE.
- ACCESS (cycle N+1 for request seen in cycle N):
  - gnt[id]=1 for exactly this cycle; address_b = latched addr; data_b = latched wdata.
  - wren_b = latched we AND addr is not SWITCHES_LOC AND addr is not LEDS_LOC.
  - Write to LEDS_LOC: seg_value <= wdata at end of cycle.
  - Write to SWITCHES_LOC: ignored (no RAM write, no state change).
  - Write: go to IDLE. Read: go to READ_WAIT.
- READ_WAIT (cycle N+2):
  - wren_b=0.
  - rdata <= {8'b0,switches} if addr==SWITCHES_LOC; seg_value if addr==LEDS_LOC; else q_b.
  - rvalid[id] high in cycle N+3 for one cycle. Go to IDLE.
- Latency and throughput:
  - Read: req seen cycle N -> gnt N+1, rvalid N+3; new request may be accepted in N+3.
  - Write: gnt N+1; next acceptance N+2.
- Requester fields need to be stable only until gnt. Dropping req before gnt withdraws the request only if the arbiter is still in IDLE.
- Other addresses in the IO window (>= IO_MEM, not the two locations) pass through to RAM normally.
- wren_b is never high outside ACCESS. gnt0 and gnt1 are never high together; likewise rvalid0/rvalid1.
- Address/data are full width; no wrap or arithmetic.
- seg_value changes only on an LEDS_LOC write or reset.

Test Plan:
- Reset, then req0 read addr 16'h0010 (RAM holds 16'hBEEF) -> gnt0 at N+1, address_b=16'h0010, rvalid0 at N+3 with rdata=16'hBEEF; gnt1/rvalid1 stay 0.
- req0 and req1 both asserted every cycle, writes to 16'h0100 / 16'h0200 -> grants alternate 0,1,0,1 on every other cycle; first grant goes to 0; wren_b pulses with matching address_b/data_b.
- req1 write 16'h1234 to LEDS_LOC -> wren_b stays 0, seg_value=16'h1234 the cycle after gnt1. Then req0 read LEDS_LOC -> rvalid0 with rdata=16'h1234.
- switches=8'hA5, req1 read SWITCHES_LOC -> rdata=16'h00A5 with rvalid1; req1 write SWITCHES_LOC -> wren_b=0, seg_value unchanged.
- req0 write 16'h5555 to 16'hCFFF (IO window, unmapped) -> wren_b=1 with address_b=16'hCFFF; readback returns 16'h5555.
- Assert reset during ACCESS of a write and during READ_WAIT of a read -> wren_b and rvalid drop immediately, no rvalid after reset release, seg_value=0, next tie is granted to requester 0.

Source files
------------

// File: rtl/mem_portb_arbiter.sv
// Round-robin arbiter and sequencer for EXRAM port B, shared by the display fetch engine (0)
// and the DMA/IO engine (1). It also decodes the switches and seg-display registers.
module mem_portb_arbiter #(
    parameter int                    WIDTH        = 16,
    parameter int                    ADDR_WIDTH   = 16,
    parameter logic [ADDR_WIDTH-1:0] IO_MEM       = 16'hCFFD,
    parameter logic [ADDR_WIDTH-1:0] SWITCHES_LOC = 16'hCFFD,
    parameter logic [ADDR_WIDTH-1:0] LEDS_LOC     = 16'hCFFE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [WIDTH-1:0]      wdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [WIDTH-1:0]      wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [WIDTH-1:0]      rdata,
    input  logic [7:0]            switches,
    output logic [WIDTH-1:0]      seg_value,
    output logic [ADDR_WIDTH-1:0] address_b,
    output logic [WIDTH-1:0]      data_b,
    output logic                  wren_b,
    input  logic [WIDTH-1:0]      q_b
);

    typedef enum logic [1:0] {IDLE, ACCESS, READ_WAIT} state_t;

    state_t                  state;
    state_t                  state_next;
    logic                    req_we;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [WIDTH-1:0]        req_wdata;
    logic                    req_id;
    logic                    last_grant;
    logic                    rvalid_p;
    logic                    any_req;
    logic                    win_id;
    logic                    is_switches;
    logic                    is_leds;

    // On a tie the requester that was not served last wins.
    assign any_req     = req0 | req1;
    assign win_id      = (req0 && req1) ? ~last_grant : req1;
    assign is_switches = (req_addr >= IO_MEM) && (req_addr == SWITCHES_LOC);
    assign is_leds     = (req_addr >= IO_MEM) && (req_addr == LEDS_LOC);

    assign address_b = req_addr;
    assign data_b    = req_wdata;
    assign rvalid0   = rvalid_p & ~req_id;
    assign rvalid1   = rvalid_p & req_id;

    always_comb begin
        state_next = state;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        wren_b     = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) state_next = ACCESS;
            end
            ACCESS: begin
                gnt0       = ~req_id;
                gnt1       = req_id;
                wren_b     = req_we & ~is_switches & ~is_leds;
                state_next = req_we ? IDLE : READ_WAIT;
            end
            READ_WAIT: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Capture the winning request; requesters may change their fields once granted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_we     <= 1'b0;
            req_addr   <= '0;
            req_wdata  <= '0;
            req_id     <= 1'b0;
            last_grant <= 1'b1;
        end else if (state == IDLE && any_req) begin
            req_we     <= win_id ? we1 : we0;
            req_addr   <= win_id ? addr1 : addr0;
            req_wdata  <= win_id ? wdata1 : wdata0;
            req_id     <= win_id;
            last_grant <= win_id;
        end
    end

    // q_b is valid in READ_WAIT, one cycle after address_b was presented in ACCESS.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rvalid_p  <= 1'b0;
            rdata     <= '0;
            seg_value <= '0;
        end else begin
            rvalid_p <= (state == READ_WAIT);
            if (state == READ_WAIT) begin
                if (is_switches)  rdata <= {{(WIDTH-8){1'b0}}, switches};
                else if (is_leds) rdata <= seg_value;
                else              rdata <= q_b;
            end
            if (state == ACCESS && req_we && is_leds) seg_value <= req_wdata;
        end
    end

endmodule

// File: tb/tb_mem_portb_arbiter.sv
// Bench for mem_portb_arbiter: a behavioural RAM on port B plus a transaction-level reference
// model (round-robin winner, fixed latencies, memory/seg/switches contents).
module tb_mem_portb_arbiter;

    localparam logic [15:0] SW_LOC  = 16'hCFFD;
    localparam logic [15:0] LED_LOC = 16'hCFFE;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, we0, req1, we1;
    logic [15:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [15:0] rdata, seg_value, address_b, data_b, q_b;
    logic [7:0]  switches;
    logic        wren_b;

    int n_cmp = 0;
    int n_fail = 0;

    logic [15:0] ref_mem [logic [15:0]];
    logic [15:0] ref_seg;
    logic        ref_last;

    logic [15:0] ram [0:65535];
    bit          ram_written [0:65535];

    always #5 clk = ~clk;

    mem_portb_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .switches(switches), .seg_value(seg_value),
        .address_b(address_b), .data_b(data_b), .wren_b(wren_b), .q_b(q_b)
    );

    function automatic logic [15:0] ram_init(input logic [15:0] a);
        return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'hA5C3);
    endfunction

    function automatic logic [15:0] ref_read(input logic [15:0] a);
        if (a == SW_LOC)  return {8'h00, switches};
        if (a == LED_LOC) return ref_seg;
        return ref_mem.exists(a) ? ref_mem[a] : ram_init(a);
    endfunction

    // Synchronous RAM, one-cycle read latency.
    always @(posedge clk) begin
        if (wren_b) begin
            ram[address_b]         <= data_b;
            ram_written[address_b] <= 1'b1;
        end
        q_b <= ram_written[address_b] ? ram[address_b] : ram_init(address_b);
    end

    task automatic run_one(input logic r0, input logic r1, input logic w0, input logic w1,
                           input logic [15:0] a0, input logic [15:0] a1,
                           input logic [15:0] d0, input logic [15:0] d1);
        logic        win, we;
        logic [15:0] a, d, exp_rd;
        logic [1:0]  exp_g;
        win = (r0 && r1) ? ~ref_last : r1;
        we  = win ? w1 : w0;
        a   = win ? a1 : a0;
        d   = win ? d1 : d0;
        ref_last = win;
        exp_g = win ? 2'b10 : 2'b01;
        @(posedge clk); #1;
        req0 = r0; req1 = r1; we0 = w0; we1 = w1; addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
        @(negedge clk);
        n_cmp++;
        if ({gnt1, gnt0} !== 2'b00) begin n_fail++; $display("FAIL gnt_early: got %b expected 00", {gnt1, gnt0}); end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if ({gnt1, gnt0} !== exp_g) begin n_fail++; $display("FAIL gnt: got %b expected %b", {gnt1, gnt0}, exp_g); end
        n_cmp++;
        if (address_b !== a) begin n_fail++; $display("FAIL address_b: got %h expected %h", address_b, a); end
        n_cmp++;
        if (wren_b !== (we && a != SW_LOC && a != LED_LOC)) begin
            n_fail++; $display("FAIL wren_b: got %b expected %b (addr %h we %b)", wren_b, we && a != SW_LOC && a != LED_LOC, a, we);
        end
        n_cmp++;
        if (seg_value !== ref_seg) begin n_fail++; $display("FAIL seg_before: got %h expected %h", seg_value, ref_seg); end
        if (we) begin
            n_cmp++;
            if (data_b !== d) begin n_fail++; $display("FAIL data_b: got %h expected %h", data_b, d); end
        end
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        we0 = 1'($urandom); we1 = 1'($urandom);
        addr0 = 16'($urandom); addr1 = 16'($urandom); wdata0 = 16'($urandom); wdata1 = 16'($urandom);
        if (we) begin
            if (a == LED_LOC) ref_seg = d;
            else if (a != SW_LOC) ref_mem[a] = d;
            @(negedge clk);
            n_cmp++;
            if (seg_value !== ref_seg) begin n_fail++; $display("FAIL seg_after: got %h expected %h", seg_value, ref_seg); end
            n_cmp++;
            if ({gnt1, gnt0, wren_b} !== 3'b000) begin n_fail++; $display("FAIL post_write_idle: got %b expected 000", {gnt1, gnt0, wren_b}); end
        end else begin
            exp_rd = ref_read(a);
            @(negedge clk);
            n_cmp++;
            if ({rvalid1, rvalid0, wren_b} !== 3'b000) begin n_fail++; $display("FAIL read_wait: got %b expected 000", {rvalid1, rvalid0, wren_b}); end
            @(posedge clk); #1;
            @(negedge clk);
            n_cmp++;
            if ({rvalid1, rvalid0} !== exp_g) begin n_fail++; $display("FAIL rvalid: got %b expected %b", {rvalid1, rvalid0}, exp_g); end
            n_cmp++;
            if (rdata !== exp_rd) begin n_fail++; $display("FAIL rdata: got %h expected %h (addr %h)", rdata, exp_rd, a); end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        switches = 8'h00;
        ref_seg = 16'h0000; ref_last = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({gnt0, gnt1, rvalid0, rvalid1, wren_b} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {gnt0, gnt1, rvalid0, rvalid1, wren_b});
        end
        n_cmp++;
        if ({address_b, data_b, rdata, seg_value} !== 64'h0) begin
            n_fail++; $display("FAIL reset_data: got %h expected 0", {address_b, data_b, rdata, seg_value});
        end
        reset = 1'b1;
    endtask

    task automatic test_back_to_back(input logic we);
        int          p;
        int          k;
        logic        first_win, wg, wr;
        logic [15:0] a;
        logic [1:0]  exp_g, exp_rv;
        logic [15:0] dv [2];
        p = we ? 2 : 3;
        k = 4;
        first_win = ~ref_last;
        dv[0] = 16'($urandom); dv[1] = 16'($urandom);
        @(posedge clk); #1;
        req0 = 1; req1 = 1; we0 = we; we1 = we; addr0 = 16'h0100; addr1 = 16'h0200;
        wdata0 = dv[0]; wdata1 = dv[1];
        for (int c = 0; c <= p * k; c++) begin
            @(negedge clk);
            exp_g = 2'b00; exp_rv = 2'b00; wg = 1'b0; wr = 1'b0;
            if (c % p == 1 && c / p < k) begin
                wg = first_win ^ 1'(c / p);
                exp_g = wg ? 2'b10 : 2'b01;
            end
            if (!we && c >= 3 && (c - 3) % 3 == 0 && (c - 3) / 3 < k) begin
                wr = first_win ^ 1'((c - 3) / 3);
                exp_rv = wr ? 2'b10 : 2'b01;
            end
            n_cmp++;
            if ({gnt1, gnt0} !== exp_g) begin n_fail++; $display("FAIL b2b_gnt c=%0d: got %b expected %b", c, {gnt1, gnt0}, exp_g); end
            if (exp_g != 2'b00) begin
                a = wg ? 16'h0200 : 16'h0100;
                n_cmp++;
                if (address_b !== a || wren_b !== we) begin
                    n_fail++; $display("FAIL b2b_access c=%0d: got %h/%b expected %h/%b", c, address_b, wren_b, a, we);
                end
                if (we) begin
                    n_cmp++;
                    if (data_b !== dv[wg]) begin n_fail++; $display("FAIL b2b_data c=%0d: got %h expected %h", c, data_b, dv[wg]); end
                    ref_mem[a] = dv[wg];
                end
            end
            if (!we) begin
                n_cmp++;
                if ({rvalid1, rvalid0} !== exp_rv) begin n_fail++; $display("FAIL b2b_rvalid c=%0d: got %b expected %b", c, {rvalid1, rvalid0}, exp_rv); end
                if (exp_rv != 2'b00) begin
                    a = wr ? 16'h0200 : 16'h0100;
                    n_cmp++;
                    if (rdata !== ref_read(a)) begin n_fail++; $display("FAIL b2b_rdata c=%0d: got %h expected %h", c, rdata, ref_read(a)); end
                end
            end
            @(posedge clk); #1;
            if (c == p * (k - 1) + 1) begin req0 = 0; req1 = 0; end
        end
        ref_last = first_win ^ 1'(k - 1);
    endtask

    task automatic test_read_basic();
        run_one(1, 0, 0, 0, 16'h0010, 16'h0000, 16'h0000, 16'h0000);
    endtask

    task automatic test_leds();
        run_one(0, 1, 0, 1, 16'h0000, LED_LOC, 16'h0000, 16'h1234);
        run_one(1, 0, 0, 0, LED_LOC, 16'h0000, 16'h0000, 16'h0000);
    endtask

    task automatic test_switches();
        switches = 8'hA5;
        run_one(0, 1, 0, 0, 16'h0000, SW_LOC, 16'h0000, 16'h0000);
        run_one(0, 1, 0, 1, 16'h0000, SW_LOC, 16'h0000, 16'hFFFF);
    endtask

    task automatic test_io_unmapped();
        run_one(1, 0, 1, 0, 16'hCFFF, 16'h0000, 16'h5555, 16'h0000);
        run_one(1, 0, 0, 0, 16'hCFFF, 16'h0000, 16'h0000, 16'h0000);
    endtask

    function automatic logic [15:0] pick_addr();
        case ($urandom_range(0, 4))
            0:       return 16'h0400 + 16'($urandom_range(0, 15));
            1:       return SW_LOC;
            2:       return LED_LOC;
            3:       return 16'hCFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic test_random();
        logic [1:0] r;
        for (int i = 0; i < 40; i++) begin
            switches = 8'($urandom);
            r = 2'($urandom_range(1, 3));
            run_one(r[0], r[1], 1'($urandom), 1'($urandom), pick_addr(), pick_addr(),
                    16'($urandom), 16'($urandom));
        end
    endtask

    task automatic test_reset_midflight();
        run_one(1, 0, 1, 0, LED_LOC, 16'h0000, 16'hABCD, 16'h0000);
        // Reset during ACCESS of a write.
        @(posedge clk); #1;
        req0 = 1; we0 = 1; addr0 = 16'h0300; wdata0 = 16'h7777;
        @(posedge clk); #1;
        req0 = 0;
        #2;
        n_cmp++;
        if (wren_b !== 1'b1) begin n_fail++; $display("FAIL mid_write_wren: got %b expected 1", wren_b); end
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({wren_b, gnt0, gnt1} !== 3'b000) begin n_fail++; $display("FAIL reset_drop_write: got %b expected 000", {wren_b, gnt0, gnt1}); end
        n_cmp++;
        if (seg_value !== 16'h0000) begin n_fail++; $display("FAIL reset_seg: got %h expected 0000", seg_value); end
        ref_seg = 16'h0000; ref_last = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        // Reset during READ_WAIT of a read.
        @(posedge clk); #1;
        req1 = 1; we1 = 0; addr1 = 16'h0010;
        @(posedge clk); #1;
        req1 = 0;
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({rvalid0, rvalid1, wren_b} !== 3'b000) begin n_fail++; $display("FAIL reset_drop_read: got %b expected 000", {rvalid0, rvalid1, wren_b}); end
        ref_last = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({rvalid0, rvalid1, gnt0, gnt1} !== 4'b0000) begin
                n_fail++; $display("FAIL post_reset_quiet c=%0d: got %b expected 0000", c, {rvalid0, rvalid1, gnt0, gnt1});
            end
        end
        // Tie after reset goes to requester 0; the aborted write must not have landed.
        run_one(1, 1, 0, 0, 16'h0300, 16'h0400, 16'h0000, 16'h0000);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish within bound");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_back_to_back(1'b1);
        test_back_to_back(1'b0);
        test_read_basic();
        test_leds();
        test_switches();
        test_io_unmapped();
        test_random();
        test_reset_midflight();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
